// File: rtl/lmsm_pkg.sv
// Shared constants and types for the LM/SM micro-op sequencer.
package lmsm_pkg;
  localparam logic [3:0] LM_OPCODE_DEF = 4'b0110;
  localparam logic [3:0] SM_OPCODE_DEF = 4'b0111;
  localparam int REGLIST_W = 8;
  localparam int REGIDX_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;
endpackage

// File: rtl/lmsm_prienc.sv
// Lowest-set-bit priority encoder over the LM/SM register list, with an any-set flag.
module lmsm_prienc
  import lmsm_pkg::*;
(
  input  logic [REGLIST_W-1:0] vec_i,
  output logic [REGIDX_W-1:0]  idx_o,
  output logic                 any_o
);

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = REGLIST_W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = REGIDX_W'(i);
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/ex_lmsm_sequencer.sv
// Expands LM/SM into one memory micro-op per cycle (R0 first), stalling RR/EX meanwhile.
// Optional LMSM_PERF_EN adds a saturating accepted-micro-op counter output.
module ex_lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter logic [3:0] LM_OPCODE = LM_OPCODE_DEF,
  parameter logic [3:0] SM_OPCODE = SM_OPCODE_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [3:0]          opcode_in,
  input  logic [15:0]         inst_in,
  input  logic [15:0]         base_in,
  input  logic                ex_ready,
  output logic                stall_out,
  output logic                pass_valid,
  output logic                uop_valid,
  output logic                uop_is_load,
  output logic [REGIDX_W-1:0] uop_reg,
  output logic [15:0]         uop_addr,
  output logic                busy
`ifdef LMSM_PERF_EN
  ,
  output logic [15:0]         perf_uop_count
`endif
);

  state_e                state_q, state_d;
  logic [REGLIST_W-1:0]  mask_q, mask_d;
  logic [15:0]           addr_q, addr_d;
  logic                  op_q, op_d;

  logic [REGIDX_W-1:0]   low_idx;
  logic                  mask_any;
  logic [REGLIST_W-1:0]  mask_clr;
  logic                  last_uop;
  logic                  is_lmsm;
  logic                  start;
  logic                  in_seq;
  logic                  unused_inst_hi;

  assign unused_inst_hi = ^inst_in[15:REGLIST_W];

  lmsm_prienc u_prienc (
    .vec_i (mask_q),
    .idx_o (low_idx),
    .any_o (mask_any)
  );

  assign mask_clr = mask_q & ~(REGLIST_W'(1) << low_idx);
  assign last_uop = mask_any & ~(|mask_clr);
  assign in_seq   = (state_q == SEQ);
  assign is_lmsm  = (opcode_in == LM_OPCODE) | (opcode_in == SM_OPCODE);
  assign start    = ~in_seq & valid_in & ~flush & is_lmsm & (|inst_in[REGLIST_W-1:0]);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    op_d    = op_q;
    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
    end else if (!in_seq) begin
      if (start) begin
        state_d = SEQ;
        mask_d  = inst_in[REGLIST_W-1:0];
        addr_d  = base_in;
        op_d    = (opcode_in == LM_OPCODE);
      end
    end else if (ex_ready) begin
      mask_d = mask_clr;
      addr_d = addr_q + 16'd1;
      if (last_uop) state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
    end
  end

  // Upstream is released in the same cycle the final micro-op is accepted.
  assign stall_out   = ~flush & (start | (in_seq & ~(ex_ready & last_uop)));
  assign pass_valid  = ~in_seq & valid_in & ~flush & ~is_lmsm;
  assign uop_valid   = in_seq;
  assign busy        = in_seq;
  assign uop_reg     = low_idx;
  assign uop_addr    = addr_q;
  assign uop_is_load = op_q;

`ifdef LMSM_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (in_seq && ex_ready && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_uop_count = perf_q;
`endif

endmodule

// File: tb/tb_ex_lmsm_sequencer.sv
// Bench for ex_lmsm_sequencer: queue-based reference model plus directed literal checks.
module tb_ex_lmsm_sequencer;

  localparam logic [3:0] LM  = 4'b0110;
  localparam logic [3:0] SM  = 4'b0111;
  localparam logic [3:0] ADD = 4'b0000;

  logic        clock = 1'b0;
  logic        reset, flush, valid_in, ex_ready;
  logic [3:0]  opcode_in;
  logic [15:0] inst_in, base_in;
  logic        stall_out, pass_valid, uop_valid, uop_is_load, busy;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
`ifdef LMSM_PERF_EN
  logic [15:0] perf_uop_count;
`endif

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Reference model: pending micro-ops as a queue of register indices.
  int          m_q[$];
  logic [15:0] m_addr = '0;
  logic        m_load = 1'b0;
  int          m_perf = 0;

  always #5 clock = ~clock;

  ex_lmsm_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .valid_in    (valid_in),
    .opcode_in   (opcode_in),
    .inst_in     (inst_in),
    .base_in     (base_in),
    .ex_ready    (ex_ready),
    .stall_out   (stall_out),
    .pass_valid  (pass_valid),
    .uop_valid   (uop_valid),
    .uop_is_load (uop_is_load),
    .uop_reg     (uop_reg),
    .uop_addr    (uop_addr),
    .busy        (busy)
`ifdef LMSM_PERF_EN
    ,
    .perf_uop_count (perf_uop_count)
`endif
  );

  function automatic bit is_lmsm(input logic [3:0] op);
    return (op == LM) || (op == SM);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      m_addr = '0;
      m_load = 1'b0;
      m_perf = 0;
    end else begin
      if (m_q.size() > 0 && ex_ready && m_perf < 65535) m_perf++;
      if (flush) begin
        m_q.delete();
      end else if (m_q.size() > 0) begin
        if (ex_ready) begin
          void'(m_q.pop_front());
          m_addr = m_addr + 16'd1;
        end
      end else if (valid_in && is_lmsm(opcode_in) && inst_in[7:0] != 8'h00) begin
        for (int i = 0; i < 8; i++) if (inst_in[i]) m_q.push_back(i);
        m_addr = base_in;
        m_load = (opcode_in == LM);
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      bit b_e, start_e, stall_e, pass_e;
      b_e     = (m_q.size() > 0);
      start_e = !b_e && valid_in && !flush && is_lmsm(opcode_in) && inst_in[7:0] != 8'h00;
      stall_e = !flush && (start_e || (b_e && !(ex_ready && m_q.size() == 1)));
      pass_e  = !b_e && valid_in && !flush && !is_lmsm(opcode_in);
      chk("m_busy", 32'(busy), 32'(b_e));
      chk("m_uop_valid", 32'(uop_valid), 32'(b_e));
      chk("m_stall", 32'(stall_out), 32'(stall_e));
      chk("m_pass", 32'(pass_valid), 32'(pass_e));
      if (b_e) begin
        chk("m_reg", 32'(uop_reg), 32'(m_q[0]));
        chk("m_addr", 32'(uop_addr), 32'(m_addr));
        chk("m_load", 32'(uop_is_load), 32'(m_load));
      end
`ifdef LMSM_PERF_EN
      chk("m_perf", 32'(perf_uop_count), 32'(m_perf));
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] op, input logic [15:0] inst,
                     input logic [15:0] base, input logic rdy);
    valid_in  = v;
    opcode_in = op;
    inst_in   = inst;
    base_in   = base;
    ex_ready  = rdy;
  endtask

  initial begin
    int exp_reg[4];
    exp_reg = '{0, 2, 5, 7};
    reset = 1'b1;
    flush = 1'b0;
    drv(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
    tick();
    tick();
    cmp_en = 1'b1;
    @(negedge clock);
    chk("rst_uop_valid", 32'(uop_valid), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_addr", 32'(uop_addr), 32'd0);
    chk("rst_reg", 32'(uop_reg), 32'd0);
    chk("rst_load", 32'(uop_is_load), 32'd0);
    tick();
    reset = 1'b0;

    // LM 1010_0101 from 0x0040.
    drv(1'b1, LM, 16'h00A5, 16'h0040, 1'b1);
    @(negedge clock);
    chk("lm_start_stall", 32'(stall_out), 32'd1);
    chk("lm_start_uv", 32'(uop_valid), 32'd0);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("lm_uv", 32'(uop_valid), 32'd1);
      chk("lm_reg", 32'(uop_reg), 32'(exp_reg[i]));
      chk("lm_addr", 32'(uop_addr), 32'h40 + 32'(i));
      chk("lm_load", 32'(uop_is_load), 32'd1);
      chk("lm_stall", 32'(stall_out), (i < 3) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clock);
    chk("lm_done_uv", 32'(uop_valid), 32'd0);

    // SM 1000_0001 from 0xFFFF: address wraps.
    tick();
    drv(1'b1, SM, 16'h0081, 16'hFFFF, 1'b1);
    tick();
    valid_in = 1'b0;
    @(negedge clock);
    chk("sm_r0_reg", 32'(uop_reg), 32'd0);
    chk("sm_r0_addr", 32'(uop_addr), 32'hFFFF);
    chk("sm_r0_load", 32'(uop_is_load), 32'd0);
    tick();
    @(negedge clock);
    chk("sm_r7_reg", 32'(uop_reg), 32'd7);
    chk("sm_r7_addr", 32'(uop_addr), 32'h0000);
    tick();

    // SM 0x03 held off by ex_ready for three cycles.
    drv(1'b1, SM, 16'h0003, 16'h1234, 1'b0);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_reg", 32'(uop_reg), 32'd0);
      chk("hold_addr", 32'(uop_addr), 32'h1234);
      chk("hold_stall", 32'(stall_out), 32'd1);
      tick();
    end
    ex_ready = 1'b1;
    @(negedge clock);
    chk("rel_r0", 32'(uop_reg), 32'd0);
    chk("rel_r0_stall", 32'(stall_out), 32'd1);
    tick();
    @(negedge clock);
    chk("rel_r1", 32'(uop_reg), 32'd1);
    chk("rel_r1_addr", 32'(uop_addr), 32'h1235);
    chk("rel_r1_stall", 32'(stall_out), 32'd0);
    tick();
    @(negedge clock);
    chk("rel_idle", 32'(busy), 32'd0);

    // Empty LM list is a NOP; ADD passes through.
    drv(1'b1, LM, 16'hFF00, 16'h0000, 1'b1);
    @(negedge clock);
    chk("nop_stall", 32'(stall_out), 32'd0);
    chk("nop_pass", 32'(pass_valid), 32'd0);
    tick();
    drv(1'b1, ADD, 16'h00FF, 16'h0000, 1'b1);
    @(negedge clock);
    chk("add_uv", 32'(uop_valid), 32'd0);
    chk("add_stall", 32'(stall_out), 32'd0);
    chk("add_pass", 32'(pass_valid), 32'd1);
    tick();

    // LM 0xFF with flush, then reset, on the third micro-op.
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, LM, 16'h00FF, 16'h0200, 1'b1);
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      if (k == 0) flush = 1'b1; else reset = 1'b1;
      @(negedge clock);
      if (k == 0) chk("flush_stall_now", 32'(stall_out), 32'd0);
      tick();
      flush = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      chk("kill_uv", 32'(uop_valid), 32'd0);
      chk("kill_stall", 32'(stall_out), 32'd0);
      if (k == 1) chk("kill_rst_addr", 32'(uop_addr), 32'd0);
      tick();
    end

`ifdef LMSM_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, LM, 16'h00FF, 16'h0000, 1'b1);
      tick();
      valid_in = 1'b0;
      for (int i = 0; i < 8; i++) tick();
    end
    @(negedge clock);
    chk("perf_16", 32'(perf_uop_count), 32'd16);
    drv(1'b1, LM, 16'h00FF, 16'h0000, 1'b1);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    ex_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    chk("perf_flush_keep", 32'(perf_uop_count), 32'd18);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("perf_rst", 32'(perf_uop_count), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      valid_in  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       opcode_in = LM;
        1:       opcode_in = SM;
        default: opcode_in = 4'($urandom);
      endcase
      inst_in   = 16'($urandom);
      if ($urandom_range(0, 9) == 0) inst_in[7:0] = 8'h00;
      base_in   = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      ex_ready  = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 199) == 0);
    end
    tick();
    @(negedge clock);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_lmsm_sequencer.md
Name: ex_lmsm_sequencer

Overview:
- Consumer on the EX side of the RR/EX pipeline register.
- Expands LM and SM (load/store multiple) into one single-register memory micro-op per cycle.
- Stalls the upstream RR/EX pipeline while the expansion runs.
- Passes all other instructions through untouched as a valid qualifier for the normal EX path.

Parameters:
- LM_OPCODE, 4'b0110, opcode value decoded as load-multiple.
- SM_OPCODE, 4'b0111, opcode value decoded as store-multiple.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous kill of any in-progress sequence, from branch resolution.
- valid_in  in  1  RR/EX valid_Reg.
- opcode_in  in  4  RR/EX opcode_Reg.
- inst_in  in  16  RR/EX Inst_Reg; bits [7:0] are the register list.
- base_in  in  16  RR/EX DataA_Reg; start address.
- ex_ready  in  1  memory stage accepts the current micro-op this cycle.
- stall_out  out  1  hold the upstream pipeline registers and the PC.
- pass_valid  out  1  non-LM/SM instruction valid for the normal EX path.
- uop_valid  out  1  micro-op present.
- uop_is_load  out  1  1 = LM micro-op (mem→Rn); 0 = SM micro-op (Rn→mem).
- uop_reg  out  3  register index for this micro-op.
- uop_addr  out  16  memory address for this micro-op.
- busy  out  1  sequence in progress.

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- States: IDLE, SEQ. Registers: mask_r[7:0], addr_r[15:0], op_r (1 = LM).
- start = state==IDLE & valid_in & ~flush & (opcode_in==LM_OPCODE | opcode_in==SM_OPCODE) & inst_in[7:0]!=0.
- Transitions:
  - IDLE→SEQ on start: mask_r←inst_in[7:0], addr_r←base_in, op_r←(opcode_in==LM_OPCODE).
  - In SEQ, when ex_ready is high: clear the lowest set bit of mask_r and set addr_r←addr_r+1.
  - SEQ→IDLE when ex_ready is high and exactly one bit remains set.
- Outputs:
  - uop_valid = (state==SEQ).
  - uop_reg = index of the lowest set bit of mask_r (R0 first, ascending order).
  - uop_addr = addr_r.
  - uop_is_load = op_r.
  - busy = (state==SEQ).
- Latency: first micro-op appears the cycle after start; N set bits give N accepted micro-ops. With ex_ready held high, the sequence occupies N cycles.
- stall_out (combinational):
  - High in the start cycle.
  - High in SEQ except the cycle in which the last micro-op is accepted (ex_ready high, one bit left). Upstream therefore advances exactly as the final micro-op retires.
- pass_valid = state==IDLE & valid_in & ~flush & ~is_lmsm.
- LM/SM with an empty list (inst_in[7:0]==0): treated as a NOP. No micro-op, no stall, pass_valid=0.
- ex_ready low in SEQ: hold all registers and outputs stable. uop_* must not change while uop_valid & ~ex_ready.
- Address arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000.
- While in SEQ, valid_in/opcode_in/inst_in/base_in are ignored.
- flush (priority below reset, above everything else): next state IDLE, mask_r←0. flush in the start cycle suppresses the start. stall_out is 0 whenever flush is high.
- Reset, including mid-sequence: state IDLE, mask_r=0, addr_r=0, op_r=0. All outputs 0 on the following cycle.

Optional Feature:
- LMSM_PERF_EN defined: adds output port perf_uop_count[15:0].
  - Counts accepted micro-ops (uop_valid & ex_ready), saturating at 16'hFFFF.
  - Cleared by reset; not cleared by flush.
- LMSM_PERF_EN undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package lmsm_pkg: LM/SM opcode constants, two-state enum (IDLE, SEQ), REGLIST_W=8, REGIDX_W=3.
- One sub-module lmsm_prienc: 8-bit to 3-bit lowest-set-bit priority encoder with any-set flag. Used for uop_reg and the one-bit-remaining detect.

Test Plan:
- LM, list 8'b1010_0101, base 16'h0040, ex_ready=1 → uops over 4 cycles:
  - reg/addr: R0/0040, R2/0041, R5/0042, R7/0043, all uop_is_load=1.
  - stall_out high from the start cycle through the 3rd uop; low on the 4th.
- SM, list 8'b1000_0001, base 16'hFFFF → R0 at FFFF, then R7 at 0000 (wrap); uop_is_load=0.
- SM, list 8'h03, ex_ready=0 for 3 cycles after start:
  - R0/base stays stable with stall_out high.
  - Release → R0, then R1, then IDLE.
- LM with list 8'h00, and ADD opcode 4'b0000 with valid_in=1 → no uop_valid and stall_out=0 for both; pass_valid=1 only for the ADD.
- LM list 8'hFF, assert flush on 3rd uop cycle → next cycle IDLE, uop_valid=0, stall_out=0. Repeat with reset → same result plus addr_r cleared.
- With LMSM_PERF_EN: two full LM 8'hFF sequences → perf_uop_count=16. A flush mid-sequence keeps the count; reset clears it to 0.
